prog_loader: RTL and testbench

//  Byte-stream program loader upstream of the instruction memory. It accepts a framed

---
 rtl/prog_loader_pkg.sv | 20 ++
 rtl/loader_csum_acc.sv | 20 ++
 rtl/prog_loader.sv | 143 ++++++++++++++
 tb/tb_prog_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Optional checksum checking is enabled by LOADER_CHECKSUM_EN.
package prog_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN,
        ST_LO,
        ST_HI,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
    localparam logic [7:0] HI_RSVD_MASK = 8'hFE;

endpackage

// File: rtl/loader_csum_acc.sv
// 8-bit wrapping sum of accepted frame bytes.
// Instantiated by prog_loader only when LOADER_CHECKSUM_EN is defined.
module loader_csum_acc (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing 9-bit words into instruction memory.
// Define LOADER_CHECKSUM_EN to expect and verify a trailing CSUM byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W   = 8,
    parameter int         INSTR_W  = 9,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_Start,
    input  logic               i_Valid,
    input  logic [7:0]         i_Data,
    output logic               o_Ready,
    output logic               o_WE,
    output logic [ADDR_W-1:0]  o_Address,
    output logic [INSTR_W-1:0] o_Instruction,
    output logic               o_CpuHold,
    output logic               o_Done,
    output logic               o_Error
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [7:0]        len_q;
    logic [7:0]        lo_q;
    logic              hi_q;
    logic              accept;
    logic              start_ev;
    logic              last_word;
    logic              hi_bad;

    assign accept   = i_Valid & o_Ready;
    assign start_ev = i_Start &
                      (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign hi_bad   = |(i_Data & HI_RSVD_MASK);
    // LEN=0 gives 0-1 = 255, so a 256-word frame ends at counter 255
    assign last_word = (8'(cnt_q) == (len_q - 8'd1));

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_ok;

    loader_csum_acc u_csum (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ev),
        .en    (accept && (state_q inside {ST_LEN, ST_LO, ST_HI})),
        .data  (i_Data),
        .sum   (csum)
    );

    assign csum_ok = (i_Data == csum);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ev) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (accept && i_Data == HDR_BYTE) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (accept) state_d = ST_LO;
            end
            ST_LO: begin
                if (accept) state_d = ST_HI;
            end
            ST_HI: begin
                if (accept) state_d = hi_bad ? ST_ERR : ST_WRITE;
            end
            ST_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                state_d = last_word ? ST_CSUM : ST_LO;
`else
                state_d = last_word ? ST_DONE : ST_LO;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) state_d = csum_ok ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE, ST_ERR: begin
                if (start_ev) state_d = ST_HDR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_Ready   = 1'b0;
        o_WE      = 1'b0;
        o_CpuHold = 1'b1;
        o_Done    = 1'b0;
        o_Error   = 1'b0;
        unique case (state_q)
            ST_IDLE: o_CpuHold = 1'b0;
            ST_HDR, ST_LEN, ST_LO, ST_HI, ST_CSUM: o_Ready = 1'b1;
            ST_WRITE: o_WE = 1'b1;
            ST_DONE: begin
                o_CpuHold = 1'b0;
                o_Done    = 1'b1;
            end
            ST_ERR: o_Error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            len_q <= '0;
            lo_q  <= '0;
            hi_q  <= 1'b0;
        end else begin
            if (start_ev) begin
                cnt_q <= '0;
            end else if (state_q == ST_WRITE && !last_word) begin
                cnt_q <= cnt_q + ADDR_W'(1);
            end
            if (accept && state_q == ST_LEN) len_q <= i_Data;
            if (accept && state_q == ST_LO)  lo_q  <= i_Data;
            if (accept && state_q == ST_HI)  hi_q  <= i_Data[0];
        end
    end

    assign o_Address     = cnt_q;
    assign o_Instruction = INSTR_W'({hi_q, lo_q});

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frame table, reset
// and restart sequences, and random frames against a frame-level model.
module tb_prog_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam bit HAS_CS = 1'b1;
`else
    localparam bit HAS_CS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       i_Start;
    logic       i_Valid;
    logic [7:0] i_Data;
    logic       o_Ready;
    logic       o_WE;
    logic [7:0] o_Address;
    logic [8:0] o_Instruction;
    logic       o_CpuHold;
    logic       o_Done;
    logic       o_Error;

    int checks = 0;
    int errors = 0;

    logic [16:0] wq[$];

    prog_loader dut (
        .clk           (clk),
        .reset         (reset),
        .i_Start       (i_Start),
        .i_Valid       (i_Valid),
        .i_Data        (i_Data),
        .o_Ready       (o_Ready),
        .o_WE          (o_WE),
        .o_Address     (o_Address),
        .o_Instruction (o_Instruction),
        .o_CpuHold     (o_CpuHold),
        .o_Done        (o_Done),
        .o_Error       (o_Error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_WE) wq.push_back({o_Address, o_Instruction});
    end

    typedef struct {
        logic [7:0]  b [8];
        int          n;
        bit          tail_cs;
        bit          exp_done;
        bit          exp_err;
        int          nw;
        logic [16:0] w [2];
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic pulse_start();
        i_Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_Start = 1'b0;
        chk("start hold", {31'd0, o_CpuHold}, 32'd1);
        chk("start clears", {30'd0, o_Done, o_Error}, 32'd0);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            i_Valid = 1'b0;
            i_Data  = 8'($urandom);
            @(negedge clk);
        end
        i_Valid = 1'b1;
        i_Data  = b;
        for (int k = 0; k < 40; k++) begin
            if (o_Ready) begin
                @(posedge clk);
                @(negedge clk);
                i_Valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL send timeout: byte %0h not accepted", b);
        i_Valid = 1'b0;
    endtask

    task automatic wait_end();
        for (int k = 0; k < 20; k++) begin
            if (o_Done || o_Error) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL end timeout: done=%0d error=%0d", o_Done, o_Error);
    endtask

    task automatic run_vec(input int i);
        int nsend;
        wq.delete();
        pulse_start();
        nsend = vt[i].n - ((vt[i].tail_cs && !HAS_CS) ? 1 : 0);
        for (int j = 0; j < nsend; j++) send(vt[i].b[j], 0);
        if (vt[i].exp_err)
            chk($sformatf("v%0d err next", i), {31'd0, o_Error}, 32'd1);
        wait_end();
        repeat (2) @(negedge clk);
        chk($sformatf("v%0d done", i), {31'd0, o_Done},
            {31'd0, vt[i].exp_done});
        chk($sformatf("v%0d error", i), {31'd0, o_Error},
            {31'd0, vt[i].exp_err});
        chk($sformatf("v%0d hold", i), {31'd0, o_CpuHold},
            {31'd0, !vt[i].exp_done});
        chk($sformatf("v%0d nwr", i), wq.size(), vt[i].nw);
        for (int j = 0; j < vt[i].nw && j < wq.size(); j++)
            chk($sformatf("v%0d wr%0d", i, j), {15'd0, wq[j]},
                {15'd0, vt[i].w[j]});
    endtask

    // Frame-level reference: n_code 0 means 256 words; mode 0 good,
    // 1 reserved HI bits set in one word, 2 corrupted checksum byte.
    task automatic run_rand(input int n_code, input int mode,
                            input int gapmax);
        logic [7:0]  s[$];
        logic [16:0] ew[$];
        logic [7:0]  sum;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [7:0]  junk;
        int          n;
        int          bad;
        bit          e_done;
        bit          e_err;
        n      = (n_code == 0) ? 256 : n_code;
        bad    = (mode == 1) ? $urandom_range(n - 1) : -1;
        e_done = 1'b0;
        e_err  = 1'b0;
        for (int j = 0; j < $urandom_range(0, 2); j++) begin
            junk = 8'($urandom);
            s.push_back((junk == 8'hA5) ? 8'h5A : junk);
        end
        s.push_back(8'hA5);
        s.push_back(8'(n_code));
        sum = 8'(n_code);
        for (int w = 0; w < n; w++) begin
            lo = 8'($urandom);
            hi = {7'd0, 1'($urandom_range(0, 1))};
            if (w == bad) hi[7:1] = 7'($urandom_range(1, 127));
            s.push_back(lo);
            s.push_back(hi);
            sum = sum + lo + hi;
            if (w == bad) begin
                e_err = 1'b1;
                break;
            end
            ew.push_back({8'(w), hi[0], lo});
        end
        if (!e_err) begin
            if (HAS_CS) begin
                s.push_back((mode == 2) ? sum + 8'd1 : sum);
                e_err  = (mode == 2);
                e_done = (mode != 2);
            end else begin
                e_done = 1'b1;
            end
        end
        wq.delete();
        pulse_start();
        foreach (s[j]) send(s[j], $urandom_range(0, gapmax));
        wait_end();
        repeat (2) @(negedge clk);
        chk($sformatf("rnd n%0d m%0d done", n, mode), {31'd0, o_Done},
            {31'd0, e_done});
        chk($sformatf("rnd n%0d m%0d error", n, mode), {31'd0, o_Error},
            {31'd0, e_err});
        chk($sformatf("rnd n%0d m%0d hold", n, mode), {31'd0, o_CpuHold},
            {31'd0, !e_done});
        chk($sformatf("rnd n%0d m%0d nwr", n, mode), wq.size(), ew.size());
        for (int j = 0; j < ew.size() && j < wq.size(); j++)
            chk($sformatf("rnd n%0d wr%0d", n, j), {15'd0, wq[j]},
                {15'd0, ew[j]});
    endtask

    initial begin
        vt[0] = '{b: '{8'hA5, 8'h02, 8'h34, 8'h01, 8'h12, 8'h00, 8'h49, 8'h00},
                  n: 7, tail_cs: 1'b1, exp_done: 1'b1, exp_err: 1'b0, nw: 2,
                  w: '{{8'd0, 9'h134}, {8'd1, 9'h012}}};
        vt[1] = '{b: '{8'hA5, 8'h02, 8'h34, 8'h01, 8'h12, 8'h00, 8'h48, 8'h00},
                  n: 7, tail_cs: 1'b1, exp_done: !HAS_CS, exp_err: HAS_CS,
                  nw: 2, w: '{{8'd0, 9'h134}, {8'd1, 9'h012}}};
        vt[2] = '{b: '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h00, 8'h7F, 8'h00},
                  n: 7, tail_cs: 1'b1, exp_done: 1'b1, exp_err: 1'b0, nw: 1,
                  w: '{{8'd0, 9'h07E}, 17'd0}};
        vt[3] = '{b: '{8'hA5, 8'h01, 8'h34, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00},
                  n: 4, tail_cs: 1'b0, exp_done: 1'b0, exp_err: 1'b1, nw: 0,
                  w: '{17'd0, 17'd0}};
        vt[4] = '{b: '{8'hA5, 8'h01, 8'hFF, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00},
                  n: 5, tail_cs: 1'b1, exp_done: 1'b1, exp_err: 1'b0, nw: 1,
                  w: '{{8'd0, 9'h1FF}, 17'd0}};

        reset   = 1'b1;
        i_Start = 1'b0;
        i_Valid = 1'b0;
        i_Data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset outputs",
            {10'd0, o_Ready, o_WE, o_Address, o_Instruction,
             o_CpuHold, o_Done, o_Error}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle hold", {31'd0, o_CpuHold}, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // reset after the first word of a 2-word frame
        wq.delete();
        pulse_start();
        send(8'hA5, 0);
        send(8'h02, 0);
        send(8'h34, 0);
        send(8'h01, 0);
        chk("latency we", {31'd0, o_WE}, 32'd1);
        chk("latency addr/data", {15'd0, o_Address, o_Instruction},
            {15'd0, 8'd0, 9'h134});
        i_Valid = 1'b1;
        i_Data  = 8'h12;
        reset   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midload reset outputs",
            {10'd0, o_Ready, o_WE, o_Address, o_Instruction,
             o_CpuHold, o_Done, o_Error}, 32'd0);
        repeat (2) @(negedge clk);
        chk("idle ignores valid", {30'd0, o_Ready, o_CpuHold}, 32'd0);
        i_Valid = 1'b0;
        run_vec(0);

        // i_Start while mid-frame must not restart the load
        wq.delete();
        pulse_start();
        send(8'hA5, 0);
        send(8'h01, 0);
        i_Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_Start = 1'b0;
        chk("restart ignored ready", {31'd0, o_Ready}, 32'd1);
        send(8'h7E, 0);
        send(8'h00, 0);
        if (HAS_CS) send(8'h7F, 1);
        wait_end();
        repeat (2) @(negedge clk);
        chk("restart ignored done", {30'd0, o_Done, o_Error}, 32'd2);
        chk("restart ignored nwr", wq.size(), 1);
        if (wq.size() > 0)
            chk("restart ignored wr", {15'd0, wq[0]}, {15'd0, 8'd0, 9'h07E});

        run_rand(0, 0, 0);
        for (int r = 0; r < 25; r++)
            run_rand($urandom_range(1, 6), $urandom_range(0, 2), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
